// File: rtl/spi_reg_bridge.sv
// Turns SPI byte frames into register-bus writes (bursts) and single reads.
// Read data is parked in miso_byte_o for the slave to shift out in the next frame.
module spi_reg_bridge #(
    parameter int ADDR_W = 7,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cs_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_valid_i,
    output logic [7:0]        miso_byte_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [7:0]        reg_rdata_i,
    output logic              protocol_err_o
);

    // state      | meaning
    // ST_IDLE    | no frame, waiting for CS falling edge
    // ST_CMD     | frame open, next byte is the command
    // ST_WRITE   | write burst, each byte goes to ptr_q then ptr_q++
    // ST_RD_WAIT | read issued, counting down RD_LAT to sample reg_rdata_i
    // ST_RD_DONE | read done, any further byte in this frame is illegal
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_RD_WAIT,
        ST_RD_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [2:0]        cnt_q;
    logic              start_pend_q;
    logic [7:0]        miso_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [7:0]        reg_wdata_q;
    logic              reg_we_q;
    logic              reg_re_q;
    logic              err_q;

    logic              cs_meta_q;
    logic              cs_sync_q;
    logic              cs_prev_q;
    logic [1:0]        flush_q;
    logic              armed_q;

    logic              cs_fall;
    logic              cs_rise;

    // A frame already open when reset releases is not a frame start: edges
    // count only after the synchroniser has flushed and seen CS high.
    assign cs_fall = armed_q & cs_prev_q & ~cs_sync_q;
    assign cs_rise = ~cs_prev_q & cs_sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            cs_prev_q <= 1'b1;
            flush_q   <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            cs_meta_q <= cs_i;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
            flush_q   <= {flush_q[0], 1'b1};
            if (flush_q[1] && cs_sync_q) armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            start_pend_q <= 1'b0;
            miso_q       <= 8'h00;
            reg_addr_q   <= '0;
            reg_wdata_q  <= 8'h00;
            reg_we_q     <= 1'b0;
            reg_re_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) state_q <= ST_CMD;
                end
                ST_CMD: begin
                    if (cs_rise) begin
                        state_q <= ST_IDLE;
                    end else if (rx_valid_i) begin
                        ptr_q <= rx_byte_i[ADDR_W-1:0];
                        if (rx_byte_i[7]) begin
                            state_q <= ST_WRITE;
                        end else begin
                            reg_addr_q   <= rx_byte_i[ADDR_W-1:0];
                            reg_re_q     <= 1'b1;
                            cnt_q        <= 3'(RD_LAT);
                            start_pend_q <= 1'b0;
                            state_q      <= ST_RD_WAIT;
                        end
                    end
                end
                ST_WRITE: begin
                    if (cs_rise) begin
                        state_q <= ST_IDLE;
                    end else if (rx_valid_i) begin
                        reg_addr_q  <= ptr_q;
                        reg_wdata_q <= rx_byte_i;
                        reg_we_q    <= 1'b1;
                        ptr_q       <= ptr_q + ADDR_W'(1);
                    end
                end
                ST_RD_WAIT: begin
                    // CS may bounce while waiting; remember whether a new frame has opened.
                    if (cs_fall)      start_pend_q <= 1'b1;
                    else if (cs_rise) start_pend_q <= 1'b0;
                    if (rx_valid_i && !cs_sync_q && !start_pend_q) err_q <= 1'b1;
                    if (cnt_q == 3'd0) begin
                        miso_q <= reg_rdata_i;
                        if (start_pend_q || cs_fall) state_q <= ST_CMD;
                        else if (cs_sync_q)          state_q <= ST_IDLE;
                        else                         state_q <= ST_RD_DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RD_DONE: begin
                    if (cs_rise)         state_q <= ST_IDLE;
                    else if (rx_valid_i) err_q   <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign miso_byte_o    = miso_q;
    assign reg_addr_o     = reg_addr_q;
    assign reg_wdata_o    = reg_wdata_q;
    assign reg_we_o       = reg_we_q;
    assign reg_re_o       = reg_re_q;
    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: directed frame table, CS/reset corner sequences and
// random frames, all checked against a frame-level model of the bridge.
module tb_spi_reg_bridge;

    localparam int ADDR_W = 7;
    localparam int RD_LAT = 2;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        cs_i = 1'b1;
    logic [7:0]  rx_byte_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  miso_byte_o;
    logic [6:0]  reg_addr_o;
    logic [7:0]  reg_wdata_o;
    logic        reg_we_o;
    logic        reg_re_o;
    logic [7:0]  reg_rdata_i;
    logic        protocol_err_o;

    spi_reg_bridge #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .cs_i           (cs_i),
        .rx_byte_i      (rx_byte_i),
        .rx_valid_i     (rx_valid_i),
        .miso_byte_o    (miso_byte_o),
        .reg_addr_o     (reg_addr_o),
        .reg_wdata_o    (reg_wdata_o),
        .reg_we_o       (reg_we_o),
        .reg_re_o       (reg_re_o),
        .reg_rdata_i    (reg_rdata_i),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } ev_t;

    typedef struct {
        logic [7:0] b0, b1, b2, b3;
        int         n;
        int         we_n, re_n, err_n;
        logic [7:0] miso;
    } vec_t;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] mem [128];
    logic [7:0] mdl_mem [128];
    bit         mem_loaded = 1'b0;
    logic [7:0] p1 = 8'hEE, p2 = 8'hEE;
    logic [7:0] exp_miso = 8'h00;
    ev_t        mon_we[$], mon_re[$], mon_err[$];
    ev_t        exp_we[$], exp_re[$], exp_err[$];
    logic [7:0] fb[$];
    int         bc[$];
    vec_t       vec [5];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Register file behind the bridge: fixed RD_LAT read pipe, garbage otherwise.
    always @(posedge clk_i) begin
        p1 <= reg_re_o ? mem[reg_addr_o] : 8'hEE;
        p2 <= p1;
    end
    assign reg_rdata_i = p2;

    always @(negedge clk_i) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 128; i++) mem[i] = mdl_mem[i];
            mem_loaded = 1'b1;
        end
        if (rst_n_i) begin
            if (reg_we_o) begin
                mon_we.push_back('{int'(reg_addr_o), int'(reg_wdata_o), cyc});
                mem[reg_addr_o] = reg_wdata_o;
            end
            if (reg_re_o)       mon_re.push_back('{int'(reg_addr_o), 0, cyc});
            if (protocol_err_o) mon_err.push_back('{0, 0, cyc});
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic start_frame();
        cs_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk_i);
        #1;
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        fb.push_back(b);
        bc.push_back(cyc);
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
    endtask

    task automatic end_frame();
        repeat (4) @(posedge clk_i);
        #1;
        cs_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
    endtask

    // Frame semantics: command byte, then either a burst of writes to
    // consecutive addresses (mod 128) or one read plus an error per extra byte.
    task automatic model_frame();
        int a;
        if (fb.size() == 0) return;
        a = int'(fb[0]) % 128;
        if (fb[0] >= 8'h80) begin
            for (int i = 1; i < fb.size(); i++) begin
                exp_we.push_back('{(a + i - 1) % 128, int'(fb[i]), bc[i] + 1});
                mdl_mem[(a + i - 1) % 128] = fb[i];
            end
        end else begin
            exp_re.push_back('{a, 0, bc[0] + 1});
            exp_miso = mdl_mem[a];
            for (int i = 1; i < fb.size(); i++) exp_err.push_back('{0, 0, bc[i] + 1});
        end
        fb.delete();
        bc.delete();
    endtask

    task automatic compare(input string nm);
        chk({nm, "_we_count"}, mon_we.size(), exp_we.size());
        for (int i = 0; i < mon_we.size() && i < exp_we.size(); i++) begin
            chk($sformatf("%s_we%0d_addr", nm, i), mon_we[i].addr, exp_we[i].addr);
            chk($sformatf("%s_we%0d_data", nm, i), mon_we[i].data, exp_we[i].data);
            chk($sformatf("%s_we%0d_cycle", nm, i), mon_we[i].cyc, exp_we[i].cyc);
        end
        chk({nm, "_re_count"}, mon_re.size(), exp_re.size());
        for (int i = 0; i < mon_re.size() && i < exp_re.size(); i++) begin
            chk($sformatf("%s_re%0d_addr", nm, i), mon_re[i].addr, exp_re[i].addr);
            chk($sformatf("%s_re%0d_cycle", nm, i), mon_re[i].cyc, exp_re[i].cyc);
        end
        chk({nm, "_err_count"}, mon_err.size(), exp_err.size());
        for (int i = 0; i < mon_err.size() && i < exp_err.size(); i++)
            chk($sformatf("%s_err%0d_cycle", nm, i), mon_err[i].cyc, exp_err[i].cyc);
        chk({nm, "_miso"}, miso_byte_o, exp_miso);
        mon_we.delete(); mon_re.delete(); mon_err.delete();
        exp_we.delete(); exp_re.delete(); exp_err.delete();
    endtask

    initial begin
        logic [7:0] cmd;
        logic [7:0] row [4];
        int         n;

        for (int i = 0; i < 128; i++) mdl_mem[i] = 8'($urandom);
        mdl_mem[8'h12] = 8'h5C;
        mdl_mem[8'h03] = 8'hA7;

        vec[0] = '{8'h85, 8'h11, 8'h22, 8'h33, 4, 3, 0, 0, 8'h00};
        vec[1] = '{8'hFF, 8'hAA, 8'hBB, 8'h00, 3, 2, 0, 0, 8'h00};
        vec[2] = '{8'h12, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0, 8'h5C};
        vec[3] = '{8'h03, 8'h00, 8'h00, 8'h00, 2, 0, 1, 1, 8'hA7};
        vec[4] = '{8'h80, 8'h01, 8'h00, 8'h00, 2, 1, 0, 0, 8'hA7};

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_miso",  miso_byte_o,    0);
        chk("rst_addr",  reg_addr_o,     0);
        chk("rst_wdata", reg_wdata_o,    0);
        chk("rst_we",    reg_we_o,       0);
        chk("rst_re",    reg_re_o,       0);
        chk("rst_err",   protocol_err_o, 0);
        rst_n_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;

        for (int v = 0; v < 5; v++) begin
            row[0] = vec[v].b0; row[1] = vec[v].b1; row[2] = vec[v].b2; row[3] = vec[v].b3;
            start_frame();
            for (int i = 0; i < vec[v].n; i++) send(row[i]);
            end_frame();
            chk($sformatf("row%0d_tbl_we_n", v),  mon_we.size(),  vec[v].we_n);
            chk($sformatf("row%0d_tbl_re_n", v),  mon_re.size(),  vec[v].re_n);
            chk($sformatf("row%0d_tbl_err_n", v), mon_err.size(), vec[v].err_n);
            chk($sformatf("row%0d_tbl_miso", v),  miso_byte_o,    vec[v].miso);
            model_frame();
            compare($sformatf("row%0d", v));
        end

        // CS released straight after a read command: the read still lands.
        start_frame();
        send(8'h12);
        cs_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        model_frame();
        compare("cs_after_read");
        start_frame();
        send(8'h90); send(8'h42);
        end_frame();
        model_frame();
        compare("clean_after_read");

        // CS glitch while the read is pending, then a fresh write frame.
        start_frame();
        @(posedge clk_i);
        #1;
        rx_byte_i = 8'h03; rx_valid_i = 1'b1; cs_i = 1'b1;
        fb.push_back(8'h03); bc.push_back(cyc);
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0; cs_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        model_frame();
        send(8'h83); send(8'h5A); send(8'h6B);
        end_frame();
        model_frame();
        compare("cs_glitch");

        // Asynchronous reset in the middle of a write burst.
        start_frame();
        send(8'h85); send(8'h11);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("midrst_addr",  reg_addr_o,  0);
        chk("midrst_wdata", reg_wdata_o, 0);
        chk("midrst_we",    reg_we_o,    0);
        chk("midrst_miso",  miso_byte_o, 0);
        model_frame();
        exp_miso = 8'h00;
        compare("pre_reset");
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        send(8'h22); send(8'h33);
        fb.delete(); bc.delete();
        end_frame();
        compare("post_reset_ignored");
        start_frame();
        send(8'h85); send(8'h22); send(8'h33);
        end_frame();
        model_frame();
        compare("post_reset_frame");

        for (int f = 0; f < 40; f++) begin
            cmd = 8'($urandom);
            n = $urandom_range(1, 4);
            start_frame();
            send(cmd);
            for (int i = 1; i < n; i++) send(8'($urandom));
            end_frame();
            model_frame();
            compare($sformatf("rand%0d", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
